tmds_channel_decode: RTL and testbench

- Receive-side counterpart of the per-channel TMDS encoder on the HDMI output path.
- Takes 10-bit parallel TMDS symbols from an external 1:10 deserializer (ISERDESE2 pair) and aligns the symbol boundary by driving the deserializer's bitslip.
- Once aligned, decodes control tokens to C0/C1 and video symbols to 8-bit pixel data with DE.
- Instantiated once per TMDS lane in the HDMI input path; output feeds the capture/DDR write side.

---
 rtl/tmds_channel_decode.sv | 209 ++++++++++++++++++++
 tb/tb_tmds_channel_decode.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decode.sv
// TMDS lane receiver: bitslip-driven symbol alignment, then control-token / video decode.
// Define TMDS_DECODE_ERR_CNT_EN to add O_Err_Cnt, a count of transition-inconsistent data symbols.
module tmds_channel_decode #(
  parameter int unsigned LOCK_CNT       = 8,
  parameter int unsigned SEARCH_TIMEOUT = 4096,
  parameter int unsigned SETTLE_CYC     = 3
) (
  input  logic        Pixl_CLK,
  input  logic        Rst_Posedge,
  input  logic [9:0]  I_Symbol,
  output logic        O_Bitslip,
  output logic [3:0]  O_Slip_Cnt,
  output logic        O_Locked,
  output logic        O_De,
  output logic        O_C0,
  output logic        O_C1,
  output logic [7:0]  O_Data
`ifdef TMDS_DECODE_ERR_CNT_EN
  ,
  output logic [15:0] O_Err_Cnt
`endif
);

  localparam int unsigned RUN_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned TO_W  = $clog2(SEARCH_TIMEOUT);
  localparam int unsigned ST_W  = $clog2(SETTLE_CYC + 1);

  localparam logic [RUN_W-1:0] RUN_FULL    = RUN_W'(LOCK_CNT);
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(SEARCH_TIMEOUT - 1);
  localparam logic [ST_W-1:0]  SETTLE_LAST = ST_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_SLIP,
    ST_SETTLE,
    ST_LOCKED
  } state_t;

  state_t           state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [ST_W-1:0]  settle_q, settle_d;
  logic [3:0]       slip_q, slip_d;

  logic             s1_ctrl_q, s1_ctrl_d;
  logic [1:0]       s1_cc_q, s1_cc_d;
  logic [7:0]       s1_data_q, s1_data_d;
  logic [7:0]       sym_d;

  logic             bitslip_q, bitslip_d;
  logic             locked_q, locked_d;
  logic             de_q, de_d;
  logic [1:0]       cc_q, cc_d;
  logic [7:0]       data_q, data_d;

  logic             run_hit, timeout;
  logic [RUN_W-1:0] run_nxt;
  logic [TO_W-1:0]  to_nxt;

`ifdef TMDS_DECODE_ERR_CNT_EN
  logic             s1_bad_q, s1_bad_d;
  logic [15:0]      err_q, err_d;
`endif

  // Stage 1: classify the incoming symbol and undo the XOR/XNOR + inversion coding.
  always_comb begin
    s1_ctrl_d = 1'b1;
    s1_cc_d   = 2'b00;
    case (I_Symbol)
      10'b1101010100: s1_cc_d = 2'b00;
      10'b0010101011: s1_cc_d = 2'b01;
      10'b0101010100: s1_cc_d = 2'b10;
      10'b1010101011: s1_cc_d = 2'b11;
      default:        s1_ctrl_d = 1'b0;
    endcase
    sym_d     = I_Symbol[9] ? ~I_Symbol[7:0] : I_Symbol[7:0];
    s1_data_d = {sym_d[7:1] ^ sym_d[6:0] ^ {7{~I_Symbol[8]}}, sym_d[0]};
`ifdef TMDS_DECODE_ERR_CNT_EN
    // An encoder only picks XNOR for bytes with at least four ones, XOR for at most four.
    s1_bad_d  = I_Symbol[8] ? ($countones(s1_data_d) > 4) : ($countones(s1_data_d) < 4);
`endif
  end

  // Alignment FSM: count control runs, slip on timeout, drop lock on a long token-free stretch.
  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    to_d     = to_q;
    settle_d = settle_q;
    slip_d   = slip_q;
    run_hit  = (run_q == RUN_FULL);
    timeout  = (to_q == TO_LAST);
    run_nxt  = s1_ctrl_q ? (run_hit ? run_q : run_q + RUN_W'(1)) : '0;
    to_nxt   = run_hit ? '0 : to_q + TO_W'(1);
    case (state_q)
      ST_SEARCH: begin
        run_d = run_nxt;
        to_d  = to_nxt;
        if (run_hit) begin
          state_d = ST_LOCKED;
        end else if (timeout) begin
          state_d = ST_SLIP;
          slip_d  = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
        end
      end
      ST_SLIP: begin
        state_d  = ST_SETTLE;
        run_d    = '0;
        to_d     = '0;
        settle_d = '0;
      end
      ST_SETTLE: begin
        run_d    = '0;
        to_d     = '0;
        settle_d = settle_q + ST_W'(1);
        if (settle_q == SETTLE_LAST) state_d = ST_SEARCH;
      end
      ST_LOCKED: begin
        run_d = run_nxt;
        to_d  = to_nxt;
        if (!run_hit && timeout) begin
          state_d = ST_SEARCH;
          run_d   = '0;
          to_d    = '0;
          slip_d  = 4'd0;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  // Stage 2: outputs follow the next lock state so gating lines up with O_Locked.
  always_comb begin
    bitslip_d = (state_d == ST_SLIP);
    locked_d  = (state_d == ST_LOCKED);
    de_d      = 1'b0;
    cc_d      = cc_q;
    data_d    = data_q;
    if (!locked_d) begin
      cc_d   = 2'b00;
      data_d = 8'h00;
    end else if (s1_ctrl_q) begin
      cc_d = s1_cc_q;
    end else begin
      de_d   = 1'b1;
      data_d = s1_data_q;
    end
`ifdef TMDS_DECODE_ERR_CNT_EN
    err_d = err_q;
    if ((state_q != ST_LOCKED) && (state_d == ST_LOCKED)) begin
      err_d = 16'h0000;
    end else if ((state_q == ST_LOCKED) && !s1_ctrl_q && s1_bad_q && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end
`endif
  end

  always_ff @(posedge Pixl_CLK or posedge Rst_Posedge) begin
    if (Rst_Posedge) begin
      state_q   <= ST_SEARCH;
      run_q     <= '0;
      to_q      <= '0;
      settle_q  <= '0;
      slip_q    <= 4'd0;
      s1_ctrl_q <= 1'b0;
      s1_cc_q   <= 2'b00;
      s1_data_q <= 8'h00;
      bitslip_q <= 1'b0;
      locked_q  <= 1'b0;
      de_q      <= 1'b0;
      cc_q      <= 2'b00;
      data_q    <= 8'h00;
`ifdef TMDS_DECODE_ERR_CNT_EN
      s1_bad_q  <= 1'b0;
      err_q     <= 16'h0000;
`endif
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      to_q      <= to_d;
      settle_q  <= settle_d;
      slip_q    <= slip_d;
      s1_ctrl_q <= s1_ctrl_d;
      s1_cc_q   <= s1_cc_d;
      s1_data_q <= s1_data_d;
      bitslip_q <= bitslip_d;
      locked_q  <= locked_d;
      de_q      <= de_d;
      cc_q      <= cc_d;
      data_q    <= data_d;
`ifdef TMDS_DECODE_ERR_CNT_EN
      s1_bad_q  <= s1_bad_d;
      err_q     <= err_d;
`endif
    end
  end

  assign O_Bitslip  = bitslip_q;
  assign O_Slip_Cnt = slip_q;
  assign O_Locked   = locked_q;
  assign O_De       = de_q;
  assign O_C0       = cc_q[0];
  assign O_C1       = cc_q[1];
  assign O_Data     = data_q;
`ifdef TMDS_DECODE_ERR_CNT_EN
  assign O_Err_Cnt  = err_q;
`endif

endmodule

// File: tb/tb_tmds_channel_decode.sv
// Randomized bench for tmds_channel_decode against a cycle-level reference model and a bit-serial link model.
module tb_tmds_channel_decode;

  localparam int unsigned LOCK_CNT       = 8;
  localparam int unsigned SEARCH_TIMEOUT = 4096;
  localparam int unsigned SETTLE_CYC     = 3;
  localparam logic [9:0]  TOK0 = 10'b1101010100;
  localparam logic [9:0]  TOK1 = 10'b0010101011;
  localparam logic [9:0]  TOK2 = 10'b0101010100;
  localparam logic [9:0]  TOK3 = 10'b1010101011;
  localparam logic [9:0]  D_ZERO = 10'b0100000000;
  localparam logic [9:0]  D_ONES = 10'b1011111111;
  localparam logic [9:0]  D_BAD  = 10'b0001010101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  sym = 10'd0;
  logic        bitslip, locked, de, c0, c1;
  logic [3:0]  slip_cnt;
  logic [7:0]  data;
`ifdef TMDS_DECODE_ERR_CNT_EN
  logic [15:0] err_cnt;
`endif

  tmds_channel_decode dut (
    .Pixl_CLK   (clk),
    .Rst_Posedge(rst),
    .I_Symbol   (sym),
    .O_Bitslip  (bitslip),
    .O_Slip_Cnt (slip_cnt),
    .O_Locked   (locked),
    .O_De       (de),
    .O_C0       (c0),
    .O_C1       (c1),
    .O_Data     (data)
`ifdef TMDS_DECODE_ERR_CNT_EN
    ,
    .O_Err_Cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: symbol classes and decode computed straight from the coding rules.
  function automatic int tok_class(input logic [9:0] s);
    case (s)
      TOK0: return 0;
      TOK1: return 1;
      TOK2: return 2;
      TOK3: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] ref_decode(input logic [9:0] s);
    logic [7:0] d, o;
    d    = s[9] ? ~s[7:0] : s[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    return o;
  endfunction

  function automatic bit ref_bad(input logic [9:0] s);
    int ones;
    ones = $countones(ref_decode(s));
    return s[8] ? (ones > 4) : (ones < 4);
  endfunction

  bit         m_locked, m_bitslip, m_de;
  int         m_hold, m_run, m_quiet, m_slips, m_err;
  logic [1:0] m_cc;
  logic [7:0] m_data;
  logic [9:0] m_s1;

  task automatic model_reset();
    m_locked = 0; m_bitslip = 0; m_de = 0;
    m_hold = 0; m_run = 0; m_quiet = 0; m_slips = 0; m_err = 0;
    m_cc = 2'b00; m_data = 8'h00; m_s1 = D_ZERO;
  endtask

  // One clock edge: m_s1 is the symbol captured one edge earlier, s is captured now.
  task automatic model_edge(input logic [9:0] s);
    int  c;
    bit  ctrl, was_locked, adv;
    c          = tok_class(m_s1);
    ctrl       = (c >= 0);
    was_locked = m_locked;
    adv        = 0;
    m_bitslip  = 0;
    if (was_locked && !ctrl && ref_bad(m_s1) && m_err < 65535) m_err++;
    if (m_hold > 0) begin
      m_hold--; m_run = 0; m_quiet = 0;
    end else if (!m_locked && m_run == LOCK_CNT) begin
      m_locked = 1; m_err = 0; adv = 1;
    end else if (!m_locked && m_quiet == SEARCH_TIMEOUT - 1) begin
      m_bitslip = 1; m_slips = (m_slips + 1) % 10; m_hold = SETTLE_CYC + 1;
      m_run = 0; m_quiet = 0;
    end else if (m_locked && m_run != LOCK_CNT && m_quiet == SEARCH_TIMEOUT - 1) begin
      m_locked = 0; m_slips = 0; m_run = 0; m_quiet = 0;
    end else begin
      adv = 1;
    end
    if (adv) begin
      m_quiet = (m_run == LOCK_CNT) ? 0 : m_quiet + 1;
      m_run   = ctrl ? ((m_run < LOCK_CNT) ? m_run + 1 : m_run) : 0;
    end
    m_de = 0;
    if (!m_locked) begin
      m_cc = 2'b00; m_data = 8'h00;
    end else if (ctrl) begin
      m_cc = 2'(c);
    end else begin
      m_de = 1; m_data = ref_decode(m_s1);
    end
    m_s1 = s;
  endtask

  function automatic logic [16:0] dut_outs();
    return {bitslip, slip_cnt, locked, de, c1, c0, data};
  endfunction

  task automatic step(input logic [9:0] s);
    sym = s;
    @(posedge clk);
    model_edge(s);
    @(negedge clk);
    check("outs", 32'(dut_outs()), 32'({m_bitslip, 4'(m_slips), m_locked, m_de, m_cc, m_data}));
`ifdef TMDS_DECODE_ERR_CNT_EN
    check("err_model", 32'(err_cnt), 32'(m_err));
`endif
  endtask

  function automatic logic [9:0] rand_data();
    logic [9:0] s;
    do s = 10'($urandom); while (tok_class(s) >= 0);
    return s;
  endfunction

  function automatic logic [9:0] rand_tok();
    case ($urandom_range(0, 3))
      0: return TOK0;
      1: return TOK1;
      2: return TOK2;
      default: return TOK3;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_outs", 32'(dut_outs()), 32'd0);
    model_reset();
    rst = 1'b0;
  endtask

  // Bit-serial link model: word stream on the wire, deserializer window offset moved by bitslip.
  logic [9:0]  w_cur, w_nxt;
  logic [19:0] pair;
  int          w_n, offs;

  function automatic logic [9:0] gen_word(input int n);
    return ((n % 100) < 12) ? TOK0 : rand_data();
  endfunction

  task automatic shift_word();
    w_cur = w_nxt;
    w_nxt = gen_word(w_n);
    w_n++;
  endtask

  initial begin
    int lock_at, drop_at, pulses, last_pulse;
    bit saw_slip, got_lock;

    model_reset();
    repeat (3) @(negedge clk);
    check("rst_outs", 32'(dut_outs()), 32'd0);
    rst = 1'b0;

    // Aligned control tokens from reset.
    lock_at = -1; saw_slip = 0;
    for (int i = 0; i < 20; i++) begin
      step(TOK0);
      if (locked && lock_at < 0) lock_at = i + 1;
      if (bitslip) saw_slip = 1;
    end
    check("lock_cycle", 32'(lock_at), 32'd10);
    check("p1_no_slip", 32'(saw_slip), 32'd0);
    check("p1_de_cc", 32'({de, c1, c0}), 32'd0);

    // Directed data decode.
    step(D_ZERO); step(D_ZERO);
    check("dec_00", 32'({de, data}), 32'h100);
    step(D_ONES); step(D_ONES);
    check("dec_ones", 32'({de, data}), 32'h1FE);

    // Random locked traffic: short blanking bursts of mixed tokens between random data lines.
    for (int line = 0; line < 30; line++) begin
      int nb, nd;
      nb = $urandom_range(4, 14);
      nd = $urandom_range(20, 120);
      for (int i = 0; i < nb; i++) step(rand_tok());
      for (int i = 0; i < nd; i++) step(rand_data());
    end

    // Control token 11, then data-only until lock is lost.
    for (int i = 0; i < 10; i++) step(TOK3);
    check("cc_11", 32'({locked, de, c1, c0}), 32'b1011);
    drop_at = -1; saw_slip = 0;
    for (int i = 0; i < 5000; i++) begin
      step(rand_data());
      if (!locked && drop_at < 0) drop_at = i;
      if (bitslip) saw_slip = 1;
    end
    check("drop_cycle", 32'(drop_at), 32'(SEARCH_TIMEOUT + 1));
    check("drop_outs", 32'({locked, de, slip_cnt}), 32'd0);
    check("drop_no_slip", 32'(saw_slip), 32'd0);

    // Relock, then asynchronous reset during active video.
    for (int i = 0; i < 12; i++) step(TOK3);
    check("relock_cc", 32'({locked, de, c1, c0}), 32'b1011);
    step(D_ZERO); step(D_ZERO);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("async_rst", 32'(dut_outs()), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    lock_at = -1;
    for (int i = 0; i < 12; i++) begin
      step(TOK1);
      if (locked && lock_at < 0) lock_at = i + 1;
    end
    check("rst_relock", 32'(lock_at), 32'd10);

    // Transition-inconsistent data symbols while locked.
    step(D_ZERO); step(D_BAD); step(D_ZERO); step(D_BAD); step(D_BAD); step(D_ONES);
    step(TOK0); step(TOK0);
`ifdef TMDS_DECODE_ERR_CNT_EN
    check("err_cnt", 32'(err_cnt), 32'd3);
`endif

    // Misaligned serial stream: three slips bring the window back onto the word boundary.
    do_reset();
    w_n = 0; offs = 10 - 3;
    w_cur = gen_word(w_n); w_n++;
    w_nxt = gen_word(w_n); w_n++;
    pulses = 0; last_pulse = -1; got_lock = 0;
    for (int i = 0; i < 20000 && !got_lock; i++) begin
      pair = {w_nxt, w_cur};
      step(10'(pair >> offs));
      shift_word();
      if (bitslip) begin
        if (last_pulse >= 0) check("slip_gap", 32'(i - last_pulse), 32'(SEARCH_TIMEOUT + SETTLE_CYC + 1));
        last_pulse = i;
        pulses++;
        offs++;
        if (offs == 10) begin
          offs = 0;
          shift_word();
        end
      end
      if (locked) got_lock = 1;
    end
    check("rot_lock", 32'(got_lock), 32'd1);
    check("rot_pulses", 32'(pulses), 32'd3);
    check("rot_slip_cnt", 32'(slip_cnt), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
